// File: rtl/cal_pkg.sv
// Shared calibration-lane definitions: code width, sync preamble defaults and
// the serializer state type. The receive aligner relies on the same preamble.
package cal_pkg;

    localparam int unsigned CAL_CODE_W = 9;
    localparam int unsigned CAL_SYNC_LEN = 16;
    localparam logic [CAL_SYNC_LEN-1:0] CAL_SYNC_PATTERN = 16'hB8B8;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StData
    } cal_state_e;

    // The bit counter must span both the preamble and one code word.
    function automatic int unsigned cal_cnt_w(input int unsigned sync_len);
        return $clog2((sync_len > CAL_CODE_W) ? sync_len : CAL_CODE_W);
    endfunction

endpackage

// File: rtl/cal_code_serializer_9b.sv
// Serializes 9-bit calibration code words MSB first onto a 1-bit lane, each
// burst led by a fixed sync preamble so the receiver can find word boundaries.
module cal_code_serializer_9b
    import cal_pkg::*;
#(
    parameter int unsigned          SYNC_LEN     = CAL_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0]  SYNC_PATTERN = CAL_SYNC_PATTERN,
    parameter logic                 IDLE_LEVEL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CAL_CODE_W-1:0] code_in,
    input  logic                  code_valid,
    input  logic                  code_last,
    output logic                  code_ready,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  sync_active,
    output logic                  busy,
    output logic                  underrun
);

    localparam int unsigned CNT_W = cal_cnt_w(SYNC_LEN);
    localparam int unsigned IDX_W = $clog2(SYNC_LEN);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CAL_CODE_W - 1);

    cal_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CAL_CODE_W-1:0] shreg_q, shreg_d;
    logic                  last_flag_q, last_flag_d;
    logic                  ser_out_q, ser_out_d;
    logic                  ser_valid_q, ser_valid_d;
    logic                  sync_active_q, sync_active_d;
    logic                  busy_q, busy_d;
    logic                  underrun_q, underrun_d;
    logic [IDX_W-1:0]      sync_idx;

    // Preamble bit to present on the next cycle while in SYNC.
    assign sync_idx = IDX_W'(SYNC_LEN - 2) - IDX_W'(cnt_q);

    assign code_ready = ((state_q == StSync) && (cnt_q == SYNC_LAST)) ||
                        ((state_q == StData) && (cnt_q == BIT_LAST) && !last_flag_q && enable);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        last_flag_d   = last_flag_q;
        ser_out_d     = ser_out_q;
        ser_valid_d   = ser_valid_q;
        sync_active_d = sync_active_q;
        underrun_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && code_valid) begin
                    state_d       = StSync;
                    cnt_d         = '0;
                    ser_out_d     = SYNC_PATTERN[SYNC_LEN-1];
                    ser_valid_d   = 1'b1;
                    sync_active_d = 1'b1;
                end
            end
            StSync: begin
                if (cnt_q != SYNC_LAST) begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    ser_out_d = SYNC_PATTERN[sync_idx];
                end
            end
            StData: begin
                if (cnt_q != BIT_LAST) begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    shreg_d   = {shreg_q[CAL_CODE_W-2:0], 1'b0};
                    ser_out_d = shreg_q[CAL_CODE_W-2];
                end else if (!code_ready) begin
                    // Orderly end of burst: last word sent or enable withdrawn.
                    state_d       = StIdle;
                    cnt_d         = '0;
                    ser_out_d     = IDLE_LEVEL;
                    ser_valid_d   = 1'b0;
                    sync_active_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (code_ready) begin
            if (code_valid) begin
                state_d       = StData;
                cnt_d         = '0;
                shreg_d       = code_in;
                last_flag_d   = code_last;
                ser_out_d     = code_in[CAL_CODE_W-1];
                ser_valid_d   = 1'b1;
                sync_active_d = 1'b0;
            end else begin
                state_d       = StIdle;
                cnt_d         = '0;
                ser_out_d     = IDLE_LEVEL;
                ser_valid_d   = 1'b0;
                sync_active_d = 1'b0;
                underrun_d    = 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            shreg_q       <= '0;
            last_flag_q   <= 1'b0;
            ser_out_q     <= IDLE_LEVEL;
            ser_valid_q   <= 1'b0;
            sync_active_q <= 1'b0;
            busy_q        <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            last_flag_q   <= last_flag_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            sync_active_q <= sync_active_d;
            busy_q        <= busy_d;
            underrun_q    <= underrun_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign sync_active = sync_active_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;

endmodule
